wb_sonar: RTL and testbench

- Wishbone slave peripheral for the robot's ultrasonic ranging sensor (HC-SR04 class), mapped as a further slave on the 32-bit conbus, alongside the gpio and spi slaves.
- Generates the trigger pulse and times the echo pulse in microseconds.
- Reports result, busy, done and timeout status to the LM32.
- Raises a level interrupt into `intr_n`; the system inverts it.

---
 rtl/wb_sonar.sv | 203 ++++++++++++++++++++
 tb/tb_wb_sonar.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sonar.sv
// wb_sonar: Wishbone slave that fires an ultrasonic ranger trigger and times its echo in microseconds.
// Define SONAR_FILTER_EN to insert a 4-sample glitch filter on the synchronized echo.
module wb_sonar #(
    parameter int clk_freq   = 100000000,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int HOLDOFF_US = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    output logic        sonar_trig,
    input  logic        sonar_echo
);
    localparam int DIV = (clk_freq / 1000000 < 1) ? 1 : clk_freq / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [23:0]   TRIG_LIM = 24'(TRIG_US);
    localparam logic [23:0]   TO_LIM   = 24'(TIMEOUT_US);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
    state_t state, state_next;

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [23:0]   us_cnt;
    logic          echo_meta, echo_sync, echo_prev, echo_lvl;
    logic          echo_rise, echo_fall;
    logic          cont, irq_en, done, timeout;
    logic [15:0]   result;
    logic [23:0]   period;
    logic          access, wr_ctrl, wr_status, wr_period, start;
    logic          finish_ok, finish_to;
    logic [31:0]   rd_data;
    logic          unused_bits;

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i, wb_dat_i[31:24]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre_cnt <= '0;
        else if (pre_cnt == PRE_MAX)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end
    assign tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= sonar_echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_lvl;
        end
    end

`ifdef SONAR_FILTER_EN
    // The level follows the synchronizer only after four consecutive differing samples.
    logic [1:0] flt_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flt_cnt  <= '0;
            echo_lvl <= 1'b0;
        end else if (echo_sync == echo_lvl) begin
            flt_cnt <= '0;
        end else if (flt_cnt == 2'd3) begin
            flt_cnt  <= '0;
            echo_lvl <= echo_sync;
        end else begin
            flt_cnt <= flt_cnt + 2'd1;
        end
    end
`else
    assign echo_lvl = echo_sync;
`endif

    assign echo_rise = echo_lvl & ~echo_prev;
    assign echo_fall = ~echo_lvl & echo_prev;

    assign access    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_ctrl   = access & wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign wr_status = access & wb_we_i & (wb_adr_i[3:2] == 2'd1);
    assign wr_period = access & wb_we_i & (wb_adr_i[3:2] == 2'd3);
    assign start     = wr_ctrl & wb_dat_i[0];

    always_comb begin
        state_next = state;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        case (state)
            IDLE:      if (start || cont) state_next = TRIG;
            TRIG:      if (us_cnt >= TRIG_LIM) state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_next = MEASURE;
                end else if (us_cnt >= TO_LIM) begin
                    finish_to  = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    finish_ok  = 1'b1;
                    state_next = HOLDOFF;
                end else if (us_cnt >= TO_LIM) begin
                    finish_to  = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF:   if (!cont || us_cnt >= period) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Trigger is registered from the next state so it is glitch-free and still drops on async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sonar_trig <= 1'b0;
        end else begin
            state      <= state_next;
            sonar_trig <= (state_next == TRIG);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            us_cnt <= '0;
        else if (state_next != state)
            us_cnt <= '0;
        else if (tick && us_cnt != 24'hFFFFFF)
            us_cnt <= us_cnt + 24'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont   <= 1'b0;
            irq_en <= 1'b0;
            period <= 24'(HOLDOFF_US);
        end else begin
            if (wr_ctrl) begin
                cont   <= wb_dat_i[1];
                irq_en <= wb_dat_i[2];
            end
            if (wr_period)
                period <= wb_dat_i[23:0];
        end
    end

    // A completion in the same cycle as a W1C write keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            result  <= '0;
            intr    <= 1'b0;
        end else begin
            if (finish_ok || finish_to) begin
                done   <= 1'b1;
                result <= (finish_to || us_cnt > 24'h00FFFF) ? 16'hFFFF : us_cnt[15:0];
            end else if (wr_status && wb_dat_i[1]) begin
                done <= 1'b0;
            end
            if (finish_to)
                timeout <= 1'b1;
            else if (wr_status && wb_dat_i[2])
                timeout <= 1'b0;
            intr <= done & irq_en;
        end
    end

    always_comb begin
        rd_data = '0;
        case (wb_adr_i[3:2])
            2'd0:    rd_data = {29'd0, irq_en, cont, 1'b0};
            2'd1:    rd_data = {29'd0, timeout, done, (state != IDLE)};
            2'd2:    rd_data = {16'd0, result};
            default: rd_data = {8'd0, period};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= (access && !wb_we_i) ? rd_data : 32'd0;
        end
    end
endmodule

// File: tb/tb_wb_sonar.sv
`timescale 1ns/1ps
// tb_wb_sonar: randomized bench for wb_sonar; a microsecond-level sensor model predicts RESULT,
// STATUS and trigger timing. Build with SONAR_FILTER_EN defined for the filtered variant.
module tb_wb_sonar;
    localparam int CLK_HZ     = 4000000;
    localparam int DIV        = CLK_HZ / 1000000;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 1000;
    localparam int HOLDOFF_US = 60000;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [31:0] wb_adr_i   = '0;
    logic [31:0] wb_dat_i   = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i   = 4'hF;
    logic        wb_stb_i   = 1'b0;
    logic        wb_cyc_i   = 1'b0;
    logic        wb_we_i    = 1'b0;
    logic        wb_ack_o;
    logic        intr;
    logic        sonar_trig;
    logic        sonar_echo = 1'b0;

    always #5 clk = ~clk;

    wb_sonar #(
        .clk_freq(CLK_HZ), .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .intr(intr), .sonar_trig(sonar_trig), .sonar_echo(sonar_echo)
    );

    int checks = 0;
    int errors = 0;

    // Trigger monitor: counts pulses, their length and the spacing between rising edges.
    int   cycle_no = 0, trig_rises = 0, trig_len = 0, trig_run = 0, rise_gap = 0, last_rise = 0;
    logic trig_prev = 1'b0;
    always @(negedge clk) begin
        cycle_no++;
        if (sonar_trig) begin
            trig_run++;
            if (!trig_prev) begin
                trig_rises++;
                rise_gap  = cycle_no - last_rise;
                last_rise = cycle_no;
            end
        end else begin
            if (trig_prev) trig_len = trig_run;
            trig_run = 0;
        end
        trig_prev = sonar_trig;
    end

    // Sensor model: mode 0 silent, 1 one echo pulse, 2 a 2-cycle glitch then a real pulse.
    int   echo_mode = 0, echo_wait_us = 0, echo_width_us = 0;
    logic sensor_busy = 1'b0;
    initial begin
        forever begin
            @(negedge sonar_trig);
            if (echo_mode != 0) begin
                sensor_busy = 1'b1;
                repeat (echo_wait_us * DIV) @(posedge clk);
                if (echo_mode == 2) begin
                    #1 sonar_echo = 1'b1;
                    repeat (2) @(posedge clk);
                    #1 sonar_echo = 1'b0;
                    repeat (30 * DIV) @(posedge clk);
                end
                #1 sonar_echo = 1'b1;
                repeat (echo_width_us * DIV) @(posedge clk);
                #1 sonar_echo = 1'b0;
                sensor_busy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input int expected, input int tol);
        checks++;
        if ($isunknown(got) || int'(got) < expected - tol || int'(got) > expected + tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, expected, tol);
        end
    endtask

    task automatic busAccess(input int idx, input logic write, input logic [31:0] wdata,
                             output logic [31:0] rdata);
        int n = 0;
        @(posedge clk); #1;
        wb_adr_i = 32'(idx * 4);
        wb_dat_i = wdata;
        wb_we_i  = write;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        checkOutput("bus_ack", 32'(wb_ack_o), 1, 0);
        rdata    = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic busWrite(input int idx, input logic [31:0] wdata);
        logic [31:0] dummy;
        busAccess(idx, 1'b1, wdata, dummy);
    endtask

    task automatic busRead(input int idx, output logic [31:0] rdata);
        busAccess(idx, 1'b0, 32'd0, rdata);
    endtask

    task automatic waitDone(output logic [31:0] st);
        int n = 0;
        do begin
            busRead(1, st);
            n++;
        end while (!st[1] && n < 8000);
    endtask

    task automatic waitTrigFall(input int rises0);
        int n = 0;
        while ((trig_rises == rises0 || sonar_trig) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic waitSensorIdle();
        int n = 0;
        while (sensor_busy && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic applyStimulus(input int mode, input int wait_us, input int width_us);
        echo_mode     = mode;
        echo_wait_us  = wait_us;
        echo_width_us = width_us;
        busWrite(0, 32'h5);
    endtask

    // Reference: the echo width in microseconds, or the saturated code when either wait times out.
    function automatic int expectResult(input int mode, input int wait_us, input int width_us);
        if (mode == 0 || wait_us >= TIMEOUT_US || width_us >= TIMEOUT_US) return 'hFFFF;
        return width_us;
    endfunction

    task automatic clearStatus();
        logic [31:0] st;
        busWrite(1, 32'h6);
        checkOutput("intr_lag", 32'(intr), 1, 0);
        @(posedge clk); #1;
        checkOutput("intr_clear", 32'(intr), 0, 0);
        busRead(1, st);
        checkOutput("status_clear", st, 0, 0);
    endtask

    task automatic runShot(input int mode, input int wait_us, input int width_us, input bit retrigger);
        logic [31:0] st, res;
        int rises0, t0, exp_res;
        bit timed_out;
        exp_res   = expectResult(mode, wait_us, width_us);
        timed_out = (exp_res == 'hFFFF);
        rises0    = trig_rises;
        applyStimulus(mode, wait_us, width_us);
        t0 = cycle_no;
        waitTrigFall(rises0);
        busRead(1, st);
        checkOutput("busy", 32'(st[0]), 1, 0);
        if (retrigger) busWrite(0, 32'h5);
        waitDone(st);
        if (mode == 0)
            checkOutput("timeout_latency", 32'(cycle_no - t0), (TRIG_US + TIMEOUT_US) * DIV, 16);
        checkOutput("status_done", 32'(st[2:1]), timed_out ? 3 : 1, 0);
        busRead(2, res);
        checkOutput("result", res, exp_res, timed_out ? 0 : 1);
        checkOutput("trig_len", 32'(trig_len), TRIG_US * DIV, DIV);
        checkOutput("trig_count", 32'(trig_rises - rises0), 1, 0);
        checkOutput("intr_set", 32'(intr), 1, 0);
        waitSensorIdle();
        clearStatus();
    endtask

    task automatic runCont();
        logic [31:0] rd;
        int n, k;
        echo_mode     = 1;
        echo_wait_us  = 30;
        echo_width_us = 20;
        busWrite(3, 32'd50);
        busRead(3, rd);
        checkOutput("period_rw", rd, 50, 0);
        k = trig_rises;
        busWrite(0, 32'h6);
        for (int j = 1; j <= 3; j++) begin
            n = 0;
            while (trig_rises < k + j + 1 && n < 2000) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("cont_gap", 32'(rise_gap), (TRIG_US + 30 + 20 + 50) * DIV, 16);
        end
        k = trig_rises;
        repeat (20 * DIV) @(posedge clk);
        busWrite(0, 32'h4);
        busWrite(1, 32'h6);
        repeat (400 * DIV) @(posedge clk);
        #1;
        checkOutput("cont_stop", 32'(trig_rises - k), 0, 0);
        busRead(1, rd);
        checkOutput("cont_final_status", rd, 2, 0);
        busRead(2, rd);
        checkOutput("cont_final_result", rd, 20, 1);
        clearStatus();
    endtask

    task automatic runGlitch();
        logic [31:0] rd;
        applyStimulus(2, 20, 100);
        waitDone(rd);
        checkOutput("glitch_status", 32'(rd[2:1]), 1, 0);
        busRead(2, rd);
`ifdef SONAR_FILTER_EN
        checkOutput("glitch_result", rd, 100, 1);
`else
        checkOutput("glitch_result", rd, 0, 1);
`endif
        waitSensorIdle();
        clearStatus();
    endtask

    task automatic runResetMid();
        logic [31:0] rd;
        int n = 0;
        echo_mode = 0;
        busWrite(0, 32'h1);
        while (!sonar_trig && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("trig_before_reset", 32'(sonar_trig), 1, 0);
        #2 rst_n = 1'b0;
        #1 checkOutput("trig_async_drop", 32'(sonar_trig), 0, 0);
        @(negedge clk) rst_n = 1'b1;
        busRead(0, rd);
        checkOutput("post_reset_ctrl", rd, 0, 0);
        busRead(1, rd);
        checkOutput("post_reset_status", rd, 0, 0);
        busRead(3, rd);
        checkOutput("post_reset_period", rd, HOLDOFF_US, 0);
    endtask

    initial begin
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        checkOutput("reset_trig", 32'(sonar_trig), 0, 0);
        checkOutput("reset_intr", 32'(intr), 0, 0);
        busRead(0, rd);
        checkOutput("reset_ctrl", rd, 0, 0);
        busRead(1, rd);
        checkOutput("reset_status", rd, 0, 0);
        busRead(2, rd);
        checkOutput("reset_result", rd, 0, 0);
        busRead(3, rd);
        checkOutput("reset_period", rd, HOLDOFF_US, 0);
        @(posedge clk); #1;
        checkOutput("dat_idle", wb_dat_o, 0, 0);

        runShot(1, 200, 580, 1'b0);
        busRead(0, rd);
        checkOutput("ctrl_readback", rd, 4, 0);
        runShot(0, 0, 0, 1'b0);
        runShot(1, 50, TIMEOUT_US + 40, 1'b0);
        for (int i = 0; i < 6; i++)
            runShot(1, int'($urandom_range(300, 20)), int'($urandom_range(600, 5)), i == 1);
        runCont();
        runGlitch();
        runResetMid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
